// File: rtl/regfile_mp_pkg.sv
// Shared register-file types: the register index type and the hard-wired zero register.
// Modules size their own index width from NREGS through regIdxWidth().
package regfile_mp_pkg;

  localparam int NREGS_DEF = 32;
  localparam int REG_IDX_W = $clog2(NREGS_DEF);

  typedef logic [REG_IDX_W-1:0] regbits_t;

  localparam regbits_t REG_ZERO = '0;

  function automatic int regIdxWidth(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_pend_ctr.sv
// One saturating pending-write counter for a single architectural register.
// clr takes priority; a simultaneous accepted inc and dec leave the count unchanged.
module rf_pend_ctr #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         nonzero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         incEff;
  logic         decEff;

  // Saturate at all-ones and stop at zero, so the count never wraps.
  always_comb begin
    incEff  = inc_i && (count_q != '1);
    decEff  = dec_i && (count_q != '0);
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (incEff && !decEff) begin
      count_d = count_q + W'(1);
    end else if (decEff && !incEff) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// pending-write scoreboard that lets decode detect RAW hazards directly.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int PEND_W = 2,
  localparam int IDX_W = regIdxWidth(NREGS)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NWR-1:0]               wen_i,
  input  logic [NWR-1:0][IDX_W-1:0]    wsel_i,
  input  logic [NWR-1:0][DATA_W-1:0]   wdat_i,
  input  logic [NRD-1:0][IDX_W-1:0]    rsel_i,
  output logic [NRD-1:0][DATA_W-1:0]   rdat_o,
  input  logic                         res_en_i,
  input  logic [IDX_W-1:0]             res_sel_i,
  output logic                         res_ok_o,
  input  logic                         flush_i,
  output logic [NREGS-1:0]             busy_o
);

  localparam logic [IDX_W-1:0]  ZERO_IDX = IDX_W'(REG_ZERO);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0]              rf_q [NREGS];
  logic [DATA_W-1:0]              rf_d [NREGS];
  logic [NREGS-1:0]               wrHit;
  logic [NREGS-1:0][PEND_W-1:0]   pend;

  // Ports are applied in ascending order so the highest-index writer wins.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
    end
    wrHit = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wen_i[p] && (wsel_i[p] != ZERO_IDX)) begin
        rf_d[wsel_i[p]]  = wdat_i[p];
        wrHit[wsel_i[p]] = 1'b1;
      end
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Bypass is suppressed while reset is held, since no write can land then.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rdat_o[r] = rf_q[rsel_i[r]];
      if ((BYPASS != 0) && nRST) begin
        for (int p = 0; p < NWR; p++) begin
          if (wen_i[p] && (wsel_i[p] == rsel_i[r])) begin
            rdat_o[r] = wdat_i[p];
          end
        end
      end
      if (rsel_i[r] == ZERO_IDX) begin
        rdat_o[r] = '0;
      end
    end
  end

  assign pend[0]   = '0;
  assign busy_o[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_ctr
    rf_pend_ctr #(
      .W(PEND_W)
    ) u_ctr (
      .CLK       (CLK),
      .nRST      (nRST),
      .inc_i     (res_en_i && (res_sel_i == IDX_W'(i))),
      .dec_i     (wrHit[i]),
      .clr_i     (flush_i),
      .count_o   (pend[i]),
      .nonzero_o (busy_o[i])
    );
  end

  assign res_ok_o = !(res_en_i && (res_sel_i != ZERO_IDX) && (pend[res_sel_i] == PEND_MAX));

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (bypass on/off) driven with the same
// directed and random stimulus, checked against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int DATA_W   = 32;
  localparam int NREGS    = 32;
  localparam int NRD      = 2;
  localparam int NWR      = 2;
  localparam int PEND_W   = 2;
  localparam int IDX_W    = 5;
  localparam int PEND_MAX = 3;

  logic                       CLK = 1'b0;
  logic                       nRST;
  logic [NWR-1:0]             wen;
  logic [NWR-1:0][IDX_W-1:0]  wsel;
  logic [NWR-1:0][DATA_W-1:0] wdat;
  logic [NRD-1:0][IDX_W-1:0]  rsel;
  logic [NRD-1:0][DATA_W-1:0] rdat;
  logic [NRD-1:0][DATA_W-1:0] rdatNb;
  logic                       resEn;
  logic [IDX_W-1:0]           resSel;
  logic                       resOk;
  logic                       resOkNb;
  logic                       flush;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busyNb;

  always #5 CLK = ~CLK;

  regfile_mp #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .PEND_W(PEND_W)
  ) dut (
    .CLK(CLK), .nRST(nRST), .wen_i(wen), .wsel_i(wsel), .wdat_i(wdat),
    .rsel_i(rsel), .rdat_o(rdat), .res_en_i(resEn), .res_sel_i(resSel),
    .res_ok_o(resOk), .flush_i(flush), .busy_o(busy)
  );

  regfile_mp #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .PEND_W(PEND_W)
  ) dutNoByp (
    .CLK(CLK), .nRST(nRST), .wen_i(wen), .wsel_i(wsel), .wdat_i(wdat),
    .rsel_i(rsel), .rdat_o(rdatNb), .res_en_i(resEn), .res_sel_i(resSel),
    .res_ok_o(resOkNb), .flush_i(flush), .busy_o(busyNb)
  );

  typedef struct {
    string                      name;
    logic [NRD-1:0][DATA_W-1:0] rd;
    logic [NRD-1:0][DATA_W-1:0] rdNb;
    logic [NREGS-1:0]           busy;
    logic                       resOk;
  } expect_t;

  expect_t     sbQ[$];
  int          errors = 0;
  int          checks = 0;
  event        checkNow;

  logic [DATA_W-1:0] refRf [NREGS];
  int                refPend [NREGS];
  bit                modelInReset;

  function automatic void resetModel();
    for (int i = 0; i < NREGS; i++) begin
      refRf[i]   = '0;
      refPend[i] = 0;
    end
  endfunction

  function automatic logic [DATA_W-1:0] refRead(input logic [IDX_W-1:0] r, input bit byp);
    logic [DATA_W-1:0] v;
    if (modelInReset || r == 0) return '0;
    v = refRf[r];
    if (byp) begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] && wsel[p] == r) v = wdat[p];
      end
    end
    return v;
  endfunction

  function automatic void pushExpect(input string name);
    expect_t e;
    e.name = name;
    for (int r = 0; r < NRD; r++) begin
      e.rd[r]   = refRead(rsel[r], 1'b1);
      e.rdNb[r] = refRead(rsel[r], 1'b0);
    end
    for (int i = 0; i < NREGS; i++) e.busy[i] = (refPend[i] != 0);
    e.resOk = !(resEn && resSel != 0 && refPend[resSel] == PEND_MAX);
    sbQ.push_back(e);
  endfunction

  // Next architectural state from the current drives: writes, reservations, flush.
  function automatic void refUpdate();
    int  hit;
    bit  incOk, decOk;
    for (int i = 1; i < NREGS; i++) begin
      hit = 0;
      for (int p = 0; p < NWR; p++) if (wen[p] && wsel[p] == i) hit = 1;
      incOk = resEn && resSel == i && refPend[i] < PEND_MAX;
      decOk = (hit != 0) && refPend[i] > 0;
      if (flush)       refPend[i] = 0;
      else if (incOk && !decOk) refPend[i] = refPend[i] + 1;
      else if (decOk && !incOk) refPend[i] = refPend[i] - 1;
    end
    for (int p = 0; p < NWR; p++) begin
      if (wen[p] && wsel[p] != 0) refRf[wsel[p]] = wdat[p];
    end
  endfunction

  task automatic checkOutput(input expect_t e);
    for (int r = 0; r < NRD; r++) begin
      checks++;
      if (rdat[r] !== e.rd[r]) begin
        errors++;
        $display("[TB] FAIL %s rdat[%0d] got=%h exp=%h", e.name, r, rdat[r], e.rd[r]);
      end
      checks++;
      if (rdatNb[r] !== e.rdNb[r]) begin
        errors++;
        $display("[TB] FAIL %s nobypass rdat[%0d] got=%h exp=%h", e.name, r, rdatNb[r], e.rdNb[r]);
      end
    end
    checks++;
    if (busy !== e.busy || busyNb !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s busy got=%h/%h exp=%h", e.name, busy, busyNb, e.busy);
    end
    checks++;
    if (resOk !== e.resOk || resOkNb !== e.resOk) begin
      errors++;
      $display("[TB] FAIL %s res_ok got=%b/%b exp=%b", e.name, resOk, resOkNb, e.resOk);
    end
  endtask

  // Monitor: drains the scoreboard on every falling edge or on demand mid-cycle.
  initial begin
    expect_t e;
    forever begin
      @(negedge CLK or checkNow);
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(
    input string            name,
    input logic [NWR-1:0]   wenV,
    input logic [IDX_W-1:0] ws0, ws1,
    input logic [DATA_W-1:0] wd0, wd1,
    input logic [IDX_W-1:0] rs0, rs1,
    input logic             re,
    input logic [IDX_W-1:0] rsl,
    input logic             fl
  );
    wen = wenV; wsel[0] = ws0; wsel[1] = ws1; wdat[0] = wd0; wdat[1] = wd1;
    rsel[0] = rs0; rsel[1] = rs1; resEn = re; resSel = rsl; flush = fl;
    pushExpect(name);
    refUpdate();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyAsyncReset();
    wen = 2'b11; wsel[0] = 5'd12; wsel[1] = 5'd13; wdat[0] = $urandom; wdat[1] = $urandom;
    rsel[0] = 5'd12; rsel[1] = 5'd3; resEn = 1'b1; resSel = 5'd12; flush = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    modelInReset = 1'b1;
    resetModel();
    pushExpect("async_reset");
    -> checkNow;
    @(posedge CLK);
    #1;
    wen = '0; resEn = 1'b0;
    nRST = 1'b1;
    modelInReset = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; wen = '0; wsel = '0; wdat = '0; rsel = '0;
    resEn = 1'b0; resSel = '0; flush = 1'b0;
    modelInReset = 1'b1;
    resetModel();
    #1;
    pushExpect("in_reset");
    -> checkNow;
    #2;
    modelInReset = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    for (int i = 0; i < NREGS; i++)
      applyStimulus("read_all", 2'b00, 0, 0, 0, 0, 5'(i), 5'(NREGS - 1 - i), 1'b0, 0, 1'b0);

    applyStimulus("bypass_wr",   2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 5, 1'b0, 0, 1'b0);
    applyStimulus("bypass_next", 2'b00, 0, 0, 0, 0, 5, 0, 1'b0, 0, 1'b0);

    applyStimulus("dual_wr_r7",  2'b11, 7, 7, 32'h11, 32'h22, 7, 0, 1'b0, 0, 1'b0);
    applyStimulus("read_r7",     2'b00, 0, 0, 0, 0, 7, 5, 1'b0, 0, 1'b0);
    applyStimulus("wr_r0",       2'b01, 0, 0, 32'hFFFFFFFF, 0, 0, 7, 1'b0, 0, 1'b0);
    applyStimulus("read_r0",     2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 4; k++)
      applyStimulus("reserve_r3", 2'b00, 0, 0, 0, 0, 3, 0, 1'b1, 3, 1'b0);
    for (int k = 0; k < 3; k++)
      applyStimulus("drain_r3",   2'b01, 3, 0, $urandom, 0, 3, 0, 1'b0, 0, 1'b0);
    applyStimulus("r3_idle",      2'b00, 0, 0, 0, 0, 3, 0, 1'b0, 0, 1'b0);

    applyStimulus("reserve_r9",   2'b00, 0, 0, 0, 0, 9, 0, 1'b1, 9, 1'b0);
    applyStimulus("res_wr_r9",    2'b10, 0, 9, 0, 32'h99, 9, 0, 1'b1, 9, 1'b0);
    applyStimulus("flush_res_r9", 2'b00, 0, 0, 0, 0, 9, 0, 1'b1, 9, 1'b1);
    applyStimulus("after_flush",  2'b00, 0, 0, 0, 0, 9, 3, 1'b0, 0, 1'b0);

    applyStimulus("prime_r12",    2'b11, 12, 13, 32'hA5A5A5A5, 32'h5A5A5A5A, 12, 13, 1'b1, 12, 1'b0);
    applyAsyncReset();
    applyStimulus("post_reset",   2'b00, 0, 0, 0, 0, 12, 13, 1'b0, 0, 1'b0);
    applyStimulus("post_reset2",  2'b00, 0, 0, 0, 0, 5, 7, 1'b0, 0, 1'b0);

    for (int n = 0; n < 600; n++)
      applyStimulus("random", 2'($urandom), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                    $urandom, $urandom, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 15)),
                    1'($urandom_range(0, 19) == 0));

    @(negedge CLK);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain left=%0d exp=0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
